cache_mem_if: RTL and testbench

- Cache-side initiator for the line-granular memory port: the read-request / response / write-enable interface the memory block serves.
- Accepts one miss from a cache (I or D) at a time.
- Writes back a dirty victim line if one is flagged, then issues a line read and waits for the matching response.
- Returns the line to the cache with a one-cycle fill pulse.
- Instantiated once per cache, between the cache array and the memory port.

---
 rtl/mem_if_pkg.sv | 28 ++
 rtl/cache_mem_if.sv | 145 ++++++++++++++
 tb/tb_cache_mem_if.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and address helpers for the cache-side memory port initiator.
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  // Widest address the alignment helper handles.
  localparam int unsigned ADDR_MAX_W = 64;

  // Number of byte-offset bits inside one line.
  function automatic int unsigned offset_bits(input int unsigned line_size);
    return $clog2(line_size / 8);
  endfunction

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_MAX_W-1:0] line_align(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int unsigned           offset);
    logic [ADDR_MAX_W-1:0] mask;
    mask = {ADDR_MAX_W{1'b1}} << offset;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_mem_if.sv
// Cache miss handler: optional victim writeback, line read, fill pulse back to the cache.
// Optional watchdog on the read wait is enabled with `define MEM_TIMEOUT_EN.
module cache_mem_if
  import mem_if_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned LINE_SIZE      = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [WORD_SIZE-1:0] miss_addr,
  input  logic                 victim_dirty,
  input  logic [WORD_SIZE-1:0] victim_addr,
  input  logic [LINE_SIZE-1:0] victim_data,
  output logic                 fill_valid,
  output logic [WORD_SIZE-1:0] fill_addr,
  output logic [LINE_SIZE-1:0] fill_data,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_res,
  input  logic [WORD_SIZE-1:0] mem_res_addr,
  input  logic [LINE_SIZE-1:0] mem_res_data,
  output logic                 mem_wenable,
  output logic [WORD_SIZE-1:0] mem_w_addr,
  output logic [LINE_SIZE-1:0] mem_w_data,
  output logic                 mem_err
);

  localparam int unsigned OFFSET = offset_bits(LINE_SIZE);

  // Reject configurations the alignment and watchdog logic cannot support.
  if ((LINE_SIZE < 8) || ((LINE_SIZE & (LINE_SIZE - 1)) != 0)) begin : g_bad_line
    $error("cache_mem_if: LINE_SIZE must be a power of two >= 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("cache_mem_if: TIMEOUT_CYCLES must be non-zero");
  end

  function automatic logic [WORD_SIZE-1:0] align_w(input logic [WORD_SIZE-1:0] a);
    return WORD_SIZE'(line_align(ADDR_MAX_W'(a), OFFSET));
  endfunction

  state_t                 state, state_nxt;
  logic [WORD_SIZE-1:0]   miss_addr_q;
  logic                   res_valid_q;
  logic [WORD_SIZE-1:0]   res_addr_q;
  logic [LINE_SIZE-1:0]   res_data_q;
  logic                   accept_c;
  logic                   res_hit_c;
  logic                   timeout_c;

  assign accept_c  = miss_valid && miss_ready;
  assign res_hit_c = res_valid_q && (res_addr_q == miss_addr_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = victim_dirty ? WB : RD_REQ;
      WB:      state_nxt = RD_REQ;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (res_hit_c)      state_nxt = DONE;
        else if (timeout_c) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and captured request/response data, loaded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_ready  <= 1'b1;
      mem_read    <= 1'b0;
      mem_wenable <= 1'b0;
      fill_valid  <= 1'b0;
      mem_addr    <= '0;
      mem_w_addr  <= '0;
      mem_w_data  <= '0;
      fill_addr   <= '0;
      fill_data   <= '0;
      miss_addr_q <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      miss_ready  <= (state_nxt == IDLE);
      mem_read    <= (state_nxt == RD_REQ);
      mem_wenable <= (state_nxt == WB);
      fill_valid  <= (state_nxt == DONE);
      if (accept_c) miss_addr_q <= align_w(miss_addr);
      if (accept_c && victim_dirty) begin
        mem_w_addr <= align_w(victim_addr);
        mem_w_data <= victim_data;
      end
      // A clean miss reads straight from the request; a dirty one from the captured copy.
      if (state_nxt == RD_REQ) mem_addr <= (state == WB) ? miss_addr_q : align_w(miss_addr);
      // Responses are registered before the compare; only those seen in RD_WAIT count.
      res_valid_q <= mem_res && (state == RD_WAIT);
      if (mem_res && (state == RD_WAIT)) begin
        res_addr_q <= align_w(mem_res_addr);
        res_data_q <= mem_res_data;
      end
      if (state_nxt == DONE) begin
        fill_addr <= miss_addr_q;
        fill_data <= res_data_q;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_c = (state == RD_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in RD_WAIT; cleared in RD_REQ, the only entry path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wait_cnt <= '0;
    else if (state == RD_REQ)  wait_cnt <= '0;
    else if (state == RD_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            mem_err <= 1'b0;
    else if (timeout_c) mem_err <= 1'b1;
  end
`else
  assign timeout_c = 1'b0;
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_if.sv
// Directed self-checking bench for cache_mem_if (covers the MEM_TIMEOUT_EN build when defined).
module tb_cache_mem_if;

  localparam int unsigned WS = 32;
  localparam int unsigned LS = 128;

  logic          clk;
  logic          rst;
  logic          miss_valid;
  logic          miss_ready;
  logic [WS-1:0] miss_addr;
  logic          victim_dirty;
  logic [WS-1:0] victim_addr;
  logic [LS-1:0] victim_data;
  logic          fill_valid;
  logic [WS-1:0] fill_addr;
  logic [LS-1:0] fill_data;
  logic          mem_read;
  logic [WS-1:0] mem_addr;
  logic          mem_res;
  logic [WS-1:0] mem_res_addr;
  logic [LS-1:0] mem_res_data;
  logic          mem_wenable;
  logic [WS-1:0] mem_w_addr;
  logic [LS-1:0] mem_w_data;
  logic          mem_err;

  cache_mem_if #(
    .WORD_SIZE      (WS),
    .LINE_SIZE      (LS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .victim_dirty (victim_dirty),
    .victim_addr  (victim_addr),
    .victim_data  (victim_data),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_res      (mem_res),
    .mem_res_addr (mem_res_addr),
    .mem_res_data (mem_res_data),
    .mem_wenable  (mem_wenable),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int n_fill   = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_read)    n_rd   = n_rd + 1;
    if (mem_wenable) n_wr   = n_wr + 1;
    if (fill_valid)  n_fill = n_fill + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a miss for one edge, then drop miss_valid; returns 1 ns into the cycle after accept.
  task automatic issue_miss(input logic [WS-1:0] a, input logic d,
                            input logic [WS-1:0] va, input logic [LS-1:0] vd);
    miss_valid   = 1'b1;
    miss_addr    = a;
    victim_dirty = d;
    victim_addr  = va;
    victim_data  = vd;
    step(1);
    miss_valid   = 1'b0;
    victim_dirty = 1'b0;
  endtask

  // Drive one memory response cycle.
  task automatic respond(input logic [WS-1:0] a, input logic [LS-1:0] dat);
    mem_res      = 1'b1;
    mem_res_addr = a;
    mem_res_data = dat;
    step(1);
    mem_res      = 1'b0;
  endtask

  logic [LS-1:0] d1;
  logic [LS-1:0] d2;
  logic [LS-1:0] vd;
  int rd0, wr0, fill0;

  initial begin
    d1 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    d2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    vd = {4{32'hA5A5_A5A5}};
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; victim_data = '0;
    mem_res = 1'b0; mem_res_addr = '0; mem_res_data = '0;
    step(2);

    // Reset state
    check("rst_miss_ready", 128'(miss_ready), 128'd1);
    check("rst_fill_valid", 128'(fill_valid), 128'd0);
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_mem_wenable", 128'(mem_wenable), 128'd0);
    check("rst_mem_err", 128'(mem_err), 128'd0);
    check("rst_fill_data", 128'(fill_data), 128'd0);
    rst = 1'b0;
    step(1);

    // Clean miss, response 3 cycles after the read pulse
    rd0 = n_rd; wr0 = n_wr; fill0 = n_fill;
    issue_miss(32'h0000_0104, 1'b0, 32'h0, '0);
    check("t1_mem_read", 128'(mem_read), 128'd1);
    check("t1_mem_addr", 128'(mem_addr), 128'h100);
    check("t1_no_wenable", 128'(mem_wenable), 128'd0);
    check("t1_busy", 128'(miss_ready), 128'd0);
    step(1);
    check("t1_read_pulse_end", 128'(mem_read), 128'd0);
    step(2);
    respond(32'h100, d1);
    check("t1_fill_not_yet", 128'(fill_valid), 128'd0);
    step(1);
    check("t1_fill_valid", 128'(fill_valid), 128'd1);
    check("t1_fill_addr", 128'(fill_addr), 128'h100);
    check("t1_fill_data", fill_data, d1);
    step(1);
    check("t1_fill_pulse_end", 128'(fill_valid), 128'd0);
    check("t1_ready_again", 128'(miss_ready), 128'd1);
    check("t1_fill_data_hold", fill_data, d1);
    check("t1_rd_count", 128'(n_rd - rd0), 128'd1);
    check("t1_wr_count", 128'(n_wr - wr0), 128'd0);
    check("t1_fill_count", 128'(n_fill - fill0), 128'd1);

    // Dirty miss: writeback first, then read; unaligned victim and response addresses
    rd0 = n_rd; wr0 = n_wr; fill0 = n_fill;
    issue_miss(32'h0000_0104, 1'b1, 32'h0000_020C, vd);
    check("t2_wenable", 128'(mem_wenable), 128'd1);
    check("t2_w_addr", 128'(mem_w_addr), 128'h200);
    check("t2_w_data", mem_w_data, vd);
    check("t2_no_read_yet", 128'(mem_read), 128'd0);
    step(1);
    check("t2_wenable_end", 128'(mem_wenable), 128'd0);
    check("t2_mem_read", 128'(mem_read), 128'd1);
    check("t2_mem_addr", 128'(mem_addr), 128'h100);
    step(1);
    respond(32'h10C, d2);
    check("t2_fill_not_yet", 128'(fill_valid), 128'd0);
    step(1);
    check("t2_fill_valid", 128'(fill_valid), 128'd1);
    check("t2_fill_addr", 128'(fill_addr), 128'h100);
    check("t2_fill_data", fill_data, d2);
    step(1);
    check("t2_rd_count", 128'(n_rd - rd0), 128'd1);
    check("t2_wr_count", 128'(n_wr - wr0), 128'd1);
    check("t2_fill_count", 128'(n_fill - fill0), 128'd1);

    // Mismatching response ignored, matching one fills
    fill0 = n_fill;
    issue_miss(32'h0000_0100, 1'b0, 32'h0, '0);
    step(1);
    respond(32'h300, d1);
    respond(32'h100, d2);
    check("t3_no_fill_on_300", 128'(fill_valid), 128'd0);
    step(1);
    check("t3_fill_valid", 128'(fill_valid), 128'd1);
    check("t3_fill_data", fill_data, d2);
    check("t3_fill_addr", 128'(fill_addr), 128'h100);
    step(1);
    check("t3_fill_count", 128'(n_fill - fill0), 128'd1);

    // miss_valid held high: second miss taken only after the first fill
    rd0 = n_rd; fill0 = n_fill;
    miss_valid = 1'b1; miss_addr = 32'h100; victim_dirty = 1'b0;
    step(1);
    miss_addr = 32'h400;
    check("t4_first_read_addr", 128'(mem_addr), 128'h100);
    step(1);
    check("t4_busy_wait", 128'(miss_ready), 128'd0);
    respond(32'h100, d1);
    check("t4_busy_hit", 128'(miss_ready), 128'd0);
    check("t4_no_early_read", 128'(mem_read), 128'd0);
    step(1);
    check("t4_fill1", 128'(fill_valid), 128'd1);
    check("t4_busy_done", 128'(miss_ready), 128'd0);
    step(1);
    check("t4_ready_idle", 128'(miss_ready), 128'd1);
    check("t4_no_read_idle", 128'(mem_read), 128'd0);
    step(1);
    check("t4_second_read", 128'(mem_read), 128'd1);
    check("t4_second_addr", 128'(mem_addr), 128'h400);
    miss_valid = 1'b0;
    step(1);
    respond(32'h400, d2);
    step(1);
    check("t4_fill2", 128'(fill_valid), 128'd1);
    check("t4_fill2_addr", 128'(fill_addr), 128'h400);
    step(1);
    check("t4_fill_count", 128'(n_fill - fill0), 128'd2);
    check("t4_rd_count", 128'(n_rd - rd0), 128'd2);

    // Reset while waiting for the response
    fill0 = n_fill;
    issue_miss(32'h0000_0500, 1'b0, 32'h0, '0);
    step(1);
    rst = 1'b1;
    #1;
    check("t5_ready", 128'(miss_ready), 128'd1);
    check("t5_fill_data_clr", fill_data, 128'd0);
    check("t5_fill_addr_clr", 128'(fill_addr), 128'd0);
    check("t5_mem_addr_clr", 128'(mem_addr), 128'd0);
    step(1);
    rst = 1'b0;
    respond(32'h500, d1);
    step(3);
    check("t5_no_fill", 128'(n_fill - fill0), 128'd0);
    check("t5_ready_after", 128'(miss_ready), 128'd1);

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no response for 8 RD_WAIT cycles
    fill0 = n_fill;
    issue_miss(32'h0000_0600, 1'b0, 32'h0, '0);
    step(8);
    check("t6_err_not_yet", 128'(mem_err), 128'd0);
    check("t6_still_busy", 128'(miss_ready), 128'd0);
    step(1);
    check("t6_err_set", 128'(mem_err), 128'd1);
    check("t6_idle", 128'(miss_ready), 128'd1);
    check("t6_no_fill_pulse", 128'(fill_valid), 128'd0);
    respond(32'h600, d1);
    step(2);
    check("t6_err_sticky", 128'(mem_err), 128'd1);
    check("t6_no_fill", 128'(n_fill - fill0), 128'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_err_cleared", 128'(mem_err), 128'd0);
`else
    // No watchdog: a long wait still completes and mem_err stays low
    issue_miss(32'h0000_0600, 1'b0, 32'h0, '0);
    step(20);
    check("t6_err_low", 128'(mem_err), 128'd0);
    check("t6_still_waiting", 128'(miss_ready), 128'd0);
    respond(32'h600, d1);
    step(1);
    check("t6_late_fill", 128'(fill_valid), 128'd1);
    check("t6_late_fill_addr", 128'(fill_addr), 128'h600);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
